// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the BCD cascade counter: digit width, largest
// decimal digit value, the digit type and a range check used when
// validating load values.
package bcd_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   // A digit is acceptable if it does not exceed the largest value allowed
   // in its position (9 for ordinary digits, TOP_MSD for the MSD).
   function automatic logic bcd_valid(input bcd_digit_t digit, input bcd_digit_t top);
      return (digit <= top);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One BCD digit of the cascade counter.
// Ports:
//   clk_i      - clock, rising edge
//   reset_i    - synchronous active-high clear
//   load_i     - load strobe (load_dig_i is already validated by the top)
//   load_dig_i - digit value to load
//   step_i     - advance this digit (all lower digits terminal and counting)
//   up_i       - 1 = up, 0 = down
//   top_i      - largest value of this digit (9, or TOP_MSD for the MSD)
//   dig_o      - current digit value
//   term_o     - digit is at its terminal value for the current direction
import bcd_pkg::*;

module bcd_digit (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       load_i,
   input  logic [3:0] load_dig_i,
   input  logic       step_i,
   input  logic       up_i,
   input  logic [3:0] top_i,
   output logic [3:0] dig_o,
   output logic       term_o
);

   bcd_digit_t dig_q, dig_d;

   assign term_o = up_i ? (dig_q == top_i) : (dig_q == 4'd0);
   assign dig_o  = dig_q;

   always_comb begin
      dig_d = dig_q;
      if (load_i) begin
         dig_d = load_dig_i;
      end else if (step_i) begin
         if (up_i) dig_d = term_o ? 4'd0 : dig_q + 4'd1;
         else      dig_d = term_o ? top_i : dig_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) dig_q <= 4'd0;
      else         dig_q <= dig_d;
   end

endmodule

// File: rtl/bcd_cascade_counter.sv
// bcd_cascade_counter
// Multi-digit BCD up/down counter with synchronous load, run/stop toggle
// and carry-in/carry-out so several instances chain directly.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high clear of all state
//   init     - each sampled 0->1 transition toggles the run flag
//   up       - 1 = count up, 0 = count down
//   cin      - count enable / carry from the lower stage
//   load     - synchronous load strobe (wins over counting)
//   load_val - BCD value to load; out-of-range values load zero
//   count    - current BCD value, digit 0 in bits [3:0]
//   cout     - combinational carry/borrow: high in the cycle that wraps
//   running  - current run flag
//   load_err - one-cycle flag after a rejected load value
import bcd_pkg::*;

module bcd_cascade_counter #(
   parameter int DIGITS  = 2,
   parameter int TOP_MSD = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                init,
   input  logic                up,
   input  logic                cin,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] count,
   output logic                cout,
   output logic                running,
   output logic                load_err
);

   localparam bcd_digit_t TOP_D = bcd_digit_t'(TOP_MSD);

   logic init_q, running_q, load_err_q;
   logic running_d, load_err_d;
   logic rise, step, load_ok;
   logic [4*DIGITS-1:0] load_digs;
   logic [DIGITS-1:0]   term;
   // en[i] = step and digits 0..i-1 all terminal; en[DIGITS] is the carry out.
   logic [DIGITS:0]     en;

   assign rise      = init & ~init_q;
   assign running_d = running_q ^ rise;
   assign step      = running_q & cin & ~load & ~reset;

   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!bcd_valid(load_val[4*i +: 4], (i == DIGITS-1) ? TOP_D : BCD_MAX))
            load_ok = 1'b0;
      end
      load_digs  = load_ok ? load_val : '0;
      load_err_d = load & ~load_ok;
   end

   assign en[0] = step;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign en[g+1] = en[g] & term[g];

      bcd_digit u_digit (
         .clk_i      (clk),
         .reset_i    (reset),
         .load_i     (load),
         .load_dig_i (load_digs[4*g +: 4]),
         .step_i     (en[g]),
         .up_i       (up),
         .top_i      ((g == DIGITS-1) ? TOP_D : BCD_MAX),
         .dig_o      (count[4*g +: 4]),
         .term_o     (term[g])
      );
   end

   assign cout     = en[DIGITS];
   assign running  = running_q;
   assign load_err = load_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         init_q     <= 1'b0;
         running_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         init_q     <= init;
         running_q  <= running_d;
         load_err_q <= load_err_d;
      end
   end

endmodule

// File: tb/tb_bcd_cascade_counter.sv
module tb_bcd_cascade_counter;

   logic       clk = 1'b0;
   logic       reset, init, up, cin, load;
   logic [7:0] load_val;
   logic [7:0] count;
   logic       cout, running, load_err;

   logic       hi_init, hi_load;
   logic [7:0] hi_load_val;
   logic [7:0] hi_count;
   logic       hi_cout, hi_running, hi_load_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_cascade_counter #(.DIGITS(2), .TOP_MSD(5)) u_lo (
      .clk      (clk),
      .reset    (reset),
      .init     (init),
      .up       (up),
      .cin      (cin),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .cout     (cout),
      .running  (running),
      .load_err (load_err)
   );

   bcd_cascade_counter #(.DIGITS(2), .TOP_MSD(5)) u_hi (
      .clk      (clk),
      .reset    (reset),
      .init     (hi_init),
      .up       (up),
      .cin      (cout),
      .load     (hi_load),
      .load_val (hi_load_val),
      .count    (hi_count),
      .cout     (hi_cout),
      .running  (hi_running),
      .load_err (hi_load_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1 time
   // unit after it, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   initial begin
      reset = 1'b1; init = 1'b0; up = 1'b1; cin = 1'b0; load = 1'b0; load_val = 8'h00;
      hi_init = 1'b0; hi_load = 1'b0; hi_load_val = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      cin = 1'b1;
      #1;
      check("rst_count", count, 8'h00);
      check("rst_running", running, 1'b0);
      check("rst_load_err", load_err, 1'b0);
      check("rst_cout", cout, 1'b0);

      // Start and count up through a full 00..59..00 cycle.
      cin = 1'b0;
      init = 1'b1;
      tick();
      init = 1'b0;
      check("start_running", running, 1'b1);
      check("start_count", count, 8'h00);
      cin = 1'b1;
      #1;
      for (int i = 0; i < 60; i++) begin
         check("up_count", count, to_bcd(i));
         check("up_cout", cout, (i == 59));
         tick();
      end
      check("up_wrap", count, 8'h00);

      // Down from 00 wraps to 59 with cout in the 00 cycle.
      up = 1'b0;
      #1;
      check("dn_cout_00", cout, 1'b1);
      tick();
      check("dn_59", count, 8'h59);
      check("dn_cout_59", cout, 1'b0);
      tick();
      check("dn_58", count, 8'h58);
      tick();
      check("dn_57", count, 8'h57);

      // Stop, then load while stopped.
      cin = 1'b0;
      init = 1'b1;
      tick();
      init = 1'b0;
      check("stop_running", running, 1'b0);
      cin = 1'b1; up = 1'b1;
      load = 1'b1; load_val = 8'h47;
      tick();
      load = 1'b0;
      check("ld47", count, 8'h47);
      check("ld47_err", load_err, 1'b0);
      tick();
      check("ld47_hold", count, 8'h47);
      load = 1'b1; load_val = 8'h6A;
      tick();
      load = 1'b0;
      check("ld6a_count", count, 8'h00);
      check("ld6a_err", load_err, 1'b1);
      tick();
      check("ld6a_err_clr", load_err, 1'b0);
      load = 1'b1; load_val = 8'h0A;
      tick();
      load = 1'b0;
      check("ld0a_count", count, 8'h00);
      check("ld0a_err", load_err, 1'b1);

      // cin gating from 08.
      load = 1'b1; load_val = 8'h08; cin = 1'b0;
      tick();
      load = 1'b0;
      init = 1'b1;
      tick();
      init = 1'b0;
      check("cin_running", running, 1'b1);
      check("cin_08", count, 8'h08);
      cin = 1'b1; #1; check("cin_cout_a", cout, 1'b0); tick(); check("cin_09a", count, 8'h09);
      cin = 1'b0; #1; check("cin_cout_b", cout, 1'b0); tick(); check("cin_09b", count, 8'h09);
      cin = 1'b1; #1; check("cin_cout_c", cout, 1'b0); tick(); check("cin_10a", count, 8'h10);
      cin = 1'b0; #1; check("cin_cout_d", cout, 1'b0); tick(); check("cin_10b", count, 8'h10);

      // Load beats a step at 59 and masks cout.
      load = 1'b1; load_val = 8'h59;
      tick();
      check("pri_59", count, 8'h59);
      cin = 1'b1; load_val = 8'h23;
      #1;
      check("pri_cout", cout, 1'b0);
      tick();
      load = 1'b0;
      check("pri_23", count, 8'h23);
      check("pri_running", running, 1'b1);

      // Reset mid-count at 37, with a load pending.
      load = 1'b1; load_val = 8'h37; cin = 1'b0;
      tick();
      load = 1'b0;
      check("mid_37", count, 8'h37);
      cin = 1'b1; reset = 1'b1; load = 1'b1; load_val = 8'h44;
      tick();
      reset = 1'b0; load = 1'b0;
      check("mid_rst_count", count, 8'h00);
      check("mid_rst_running", running, 1'b0);

      // Chain: load 59 together with init rise on low stage; start high stage.
      cin = 1'b0; up = 1'b1;
      load = 1'b1; load_val = 8'h59; init = 1'b1; hi_init = 1'b1;
      tick();
      load = 1'b0; init = 1'b0; hi_init = 1'b0;
      check("ch_lo_59", count, 8'h59);
      check("ch_lo_running", running, 1'b1);
      check("ch_hi_running", hi_running, 1'b1);
      check("ch_hi_00", hi_count, 8'h00);
      cin = 1'b1;
      #1;
      check("ch_lo_cout", cout, 1'b1);
      check("ch_hi_cout", hi_cout, 1'b0);
      tick();
      check("ch_lo_00", count, 8'h00);
      check("ch_hi_01", hi_count, 8'h01);
      tick();
      check("ch_lo_01", count, 8'h01);
      check("ch_hi_hold", hi_count, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_cascade_counter.md
# bcd_cascade_counter

Parametrised multi-digit BCD up/down counter with synchronous load, carry-in/carry-out cascading and a run/stop toggle input. It is the generalised replacement for the single-digit 0–9 counter used in the lab clock and timer datapaths. One instance covers a full field such as seconds (00–59) or a 0–9999 event counter. Several instances chain through `cin`/`cout` with no extra glue.

## Interface
- `DIGITS`, 2 — number of BCD digits (1..8); digit 0 is least significant.
- `TOP_MSD`, 9 — largest value of the most significant digit (1..9); e.g. 5 gives a 00–59 counter.
- `clk` in 1 — single clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-high; clears all state.
- `init` in 1 — level input; each 0→1 transition (sampled on `clk`) toggles the run flag.
- `up` in 1 — 1 = count up, 0 = count down; sampled every cycle.
- `cin` in 1 — count enable / carry from the lower cascade stage.
- `load` in 1 — synchronous load strobe.
- `load_val` in 4·DIGITS — BCD value to load.
- `count` out 4·DIGITS — current BCD value.
- `cout` out 1 — combinational carry/borrow to the next stage.
- `running` out 1 — current run flag.
- `load_err` out 1 — registered 1-cycle flag for an invalid load value.

## Operation
- Run flag:
  - `init_q` registers `init`.
  - `rise = init & ~init_q`.
  - `running` toggles when `rise` is 1.
  - Reset forces `running` = 0 and `init_q` = 0.
- Priority per cycle: reset > load > count > hold.
- Load:
  - Happens regardless of `running` or `cin`.
  - If every digit is ≤9 and the MSD is ≤`TOP_MSD`, `count` ← `load_val`.
  - Otherwise `count` ← 0 and `load_err` = 1 for the next cycle.
  - `load_err` is 0 in every other cycle.
- Step condition: `step = running & cin & ~load & ~reset`.
- Terminal digit:
  - Counting up: 9, or `TOP_MSD` for the MSD.
  - Counting down: 0 for every digit.
- Digit i changes when `step` is 1 and digits 0..i−1 are all terminal:
  - Up: terminal → 0, otherwise +1.
  - Down: 0 → 9 (`TOP_MSD` for the MSD), otherwise −1.
- Wrap-around:
  - Up from the maximum value (MSD=`TOP_MSD`, others 9) goes to all zero.
  - Down from all zero goes to the maximum value.
- `cout = step & (all digits terminal for current up)`. It is high in exactly the cycle whose edge performs the wrap.
- `count` never holds a non-BCD digit or an MSD above `TOP_MSD`.
- A change of `up` between cycles simply reverses direction from the current value; there is no extra latency.

## Timing
- Reset values:
  - `count` = 0, `running` = 0, `load_err` = 0.
  - `cout` = 0, because `running` = 0.
- `count` updates 1 clock after the qualifying edge of `load` or `step`.
- `running` changes 1 clock after the `init` rise is sampled. The first step can therefore occur on the edge after that.
- `cout` is combinational from `count`, `up`, `cin`, `running` and `load`. Chained stages see it in the same cycle and step on the same edge.
- Depth is 1 LUT chain per digit (the lookahead AND of lower terminals); there is no multi-cycle path.
- Simultaneous `load` and `init` rise: the load applies and `running` toggles, both on the same edge.
- Reset asserted mid-count or during a load: state clears on that edge and the load is discarded.

## Structure
- Package `bcd_pkg` holds:
  - `BCD_W` = 4 and `BCD_MAX` = 4'd9.
  - Function `bcd_valid(digit, top)`.
  - A `bcd_digit_t` 4-bit typedef.
- Natural sub-module `bcd_digit`, instantiated DIGITS times via generate. It contains:
  - Inputs: clock, reset, load, load digit, step_in, up, top value.
  - Outputs: digit value and terminal flag.
- The top level owns:
  - the run flag and `init` edge detector;
  - load validation and `load_err`;
  - the terminal AND chain and `cout`.

## Test plan
Parameters for all scenarios: DIGITS=2, TOP_MSD=5.
- Reset, then `init` pulse, then `cin`=1, `up`=1 for 60 cycles: `count` goes 00→59→00. `cout`=1 only in the cycle `count`=59.
- Running, `up`=0 from 00: next value 59 with `cout`=1 in the 00 cycle; then 58, 57…
- `load_val`=8'h47 while stopped: `count`=47 next cycle and stays 47 because `running`=0. `load_val`=8'h6A: `count`=00 and `load_err`=1 for one cycle.
- Running with `cin` toggling 1,0,1,0 from 08: `count` = 09, 09, 10, 10. `cout` is never asserted.
- Load asserted together with a step at 59 up: `count` = `load_val` and `cout`=0. Reset asserted at 37 mid-count: `count`=00 and `running`=0 next cycle.
- Two instances chained (low `cout` → high `cin`), both running, `up`=1: low 59→00 and high 00→01 on the same edge.
